coin_acceptor: RTL and testbench

- Upstream front end of the vending machine controller.
- Converts the raw coin-slot sensor into clean per-coin money codes: 4'b0101 (5 units) or 4'b1010 (10 units).
- Synchronises and debounces the sensor, classifies each coin by pulse width, and buffers accepted coins in a small FIFO.
- Presents one coin at a time to the controller's money input under a valid/ready handshake; out-of-range coins and coins arriving when the FIFO is full are rejected.

---
 rtl/coin_pkg.sv | 23 ++
 rtl/coin_debounce.sv | 56 +++++
 rtl/coin_acceptor.sv | 162 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared constants and state encoding for the coin-slot front end.
// Pure definitions; no logic and no latency.
// No handshake here; the users of these definitions handle flow control.
package coin_pkg;

    // Money codes presented on the controller's money input
    localparam logic [3:0] MONEY_NONE = 4'b0000;
    localparam logic [3:0] MONEY_5    = 4'b0101;
    localparam logic [3:0] MONEY_10   = 4'b1010;

    // Default pulse-width windows, in clocks of debounced-high time
    localparam int W5_MIN_DEF  = 8;
    localparam int W5_MAX_DEF  = 15;
    localparam int W10_MIN_DEF = 20;
    localparam int W10_MAX_DEF = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        JAM     = 2'd2
    } state_t;

endpackage

// File: rtl/coin_debounce.sv
// Synchronises the raw coin sensor and debounces it with a stability counter.
// Latency: SYNC_STAGES + DEBOUNCE cycles from a raw edge to the debounced edge.
// No backpressure: the level and its rise/fall strobes are produced every cycle.
module coin_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        stable_cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous sensor through the synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Flip the debounced level after DEBOUNCE consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (synced == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_W'(DEBOUNCE - 1)) begin
                level      <= synced;
                rise       <= synced;
                fall       <= ~synced;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Classifies debounced coin pulses by width and queues accepted coins in a FIFO.
// Latency: coin code valid one cycle after the debounced falling edge (sensor + 2+4+1).
// Backpressure: money_ready stalls the FIFO head; coins arriving when full are rejected.
// Optional COIN_TOTAL_EN adds an 8-bit saturating credit_total of accepted coins.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 6,
    parameter int W5_MIN      = W5_MIN_DEF,
    parameter int W5_MAX      = W5_MAX_DEF,
    parameter int W10_MIN     = W10_MIN_DEF,
    parameter int W10_MAX     = W10_MAX_DEF,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_sense,
    output logic [3:0] money,
    output logic       money_valid,
    input  logic       money_ready,
    output logic       coin_reject,
    output logic       fifo_full,
    output logic       busy
`ifdef COIN_TOTAL_EN
    ,
    output logic [7:0] credit_total
`endif
);

    localparam int                AW       = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_JAM  = CNT_MAX - 1'b1;
    localparam logic [AW:0]       FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic            deb_level;
    logic            deb_rise;
    logic            deb_fall;
    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]      code_c;
    logic            push;
    logic            pop;
    logic [3:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    coin_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE   (DEBOUNCE)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .din  (coin_sense),
        .level(deb_level),
        .rise (deb_rise),
        .fall (deb_fall)
    );

    // Map the measured width onto a money code; out-of-window widths give none
    always_comb begin
        code_c = MONEY_NONE;
        if (cnt >= CNT_W'(W5_MIN) && cnt <= CNT_W'(W5_MAX)) begin
            code_c = MONEY_5;
        end else if (cnt >= CNT_W'(W10_MIN) && cnt <= CNT_W'(W10_MAX)) begin
            code_c = MONEY_10;
        end
    end

    // Fullness is judged on the pre-pop occupancy so a full FIFO always rejects
    assign push        = (state == MEASURE) && deb_fall && (code_c != MONEY_NONE) && !fifo_full;
    assign pop         = money_valid && money_ready;
    assign money_valid = (count != '0);
    assign money       = money_valid ? mem[rd_ptr] : MONEY_NONE;
    assign fifo_full   = (count == FULL_CNT);
    assign busy        = (state != IDLE);

    // Measurement FSM: width counting, jam detection and reject pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (deb_rise) begin
                        cnt   <= CNT_W'(1);
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (deb_fall) begin
                        state <= IDLE;
                        if (code_c == MONEY_NONE || fifo_full) begin
                            coin_reject <= 1'b1;
                        end
                    end else if (cnt == CNT_JAM) begin
                        cnt   <= CNT_MAX;
                        state <= JAM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                JAM: begin
                    if (!deb_level) begin
                        coin_reject <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps the count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only observed while the occupancy says valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code_c;
        end
    end

`ifdef COIN_TOTAL_EN
    logic [8:0] credit_sum;
    // The 5/10 codes double as their numeric value
    assign credit_sum = {1'b0, credit_total} + {5'b0, code_c};

    // Running total of accepted coins, saturating at 255
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_total <= '0;
        end else if (push) begin
            credit_total <= credit_sum[8] ? 8'hFF : credit_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: reset, width table, corner sequences,
// and a randomized run scored against a cycle-level behavioural model.
module tb_coin_acceptor;

    localparam int LAT = 6;   // raw edge to debounced edge: 2 sync + 4 debounce
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_sense;
    logic       money_ready;
    logic [3:0] money;
    logic       money_valid;
    logic       coin_reject;
    logic       fifo_full;
    logic       busy;
`ifdef COIN_TOTAL_EN
    logic [7:0] credit_total;
`endif

    coin_acceptor dut (
        .clk        (clk),
        .reset      (reset),
        .coin_sense (coin_sense),
        .money      (money),
        .money_valid(money_valid),
        .money_ready(money_ready),
        .coin_reject(coin_reject),
        .fifo_full  (fifo_full),
        .busy       (busy)
`ifdef COIN_TOTAL_EN
        ,
        .credit_total(credit_total)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] s_money;
    logic       s_valid, s_rej, s_full, s_busy;

    typedef struct {
        int         w;
        logic [3:0] code;
        int         rej;
    } vec_t;

    typedef struct {
        int         t;
        logic [3:0] code;
    } ev_t;

    vec_t       vecs[13];
    ev_t        evq[$];
    logic [3:0] mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, then step past the next edge
    task automatic cyc();
        @(negedge clk);
        s_money = money;
        s_valid = money_valid;
        s_rej   = coin_reject;
        s_full  = fifo_full;
        s_busy  = busy;
        @(posedge clk);
        #1;
    endtask

    // Drive a w-cycle high pulse (optionally with a low glitch) then tail lows
    task automatic run_pulse(input int w, input int tail, input int g_at, input int g_len,
                             output int vcnt, output logic [3:0] code,
                             output int rcnt, output int bcnt);
        vcnt = 0; code = 4'b0000; rcnt = 0; bcnt = 0;
        for (int i = 0; i < w + tail; i++) begin
            coin_sense = (i < w) && !(i >= g_at && i < g_at + g_len);
            cyc();
            if (s_valid) begin
                vcnt++;
                code = s_money;
            end
            if (s_rej)  rcnt++;
            if (s_busy) bcnt++;
        end
        coin_sense = 1'b0;
    endtask

    // Spec-level classification of a debounced width
    function automatic logic [3:0] ref_code(input int w);
        if (w >= 8 && w <= 15)  return 4'b0101;
        if (w >= 20 && w <= 31) return 4'b1010;
        return 4'b0000;
    endfunction

    initial begin
        int         vc, rc, bc;
        logic [3:0] cd;
        int         rem_hi, rem_lo, ready_pct, w, rej_pend, mcredit;
        logic       full_before;
        ev_t        ev;

        vecs[0]  = '{10, 4'b0101, 0};
        vecs[1]  = '{25, 4'b1010, 0};
        vecs[2]  = '{17, 4'b0000, 1};
        vecs[3]  = '{8,  4'b0101, 0};
        vecs[4]  = '{15, 4'b0101, 0};
        vecs[5]  = '{7,  4'b0000, 1};
        vecs[6]  = '{16, 4'b0000, 1};
        vecs[7]  = '{19, 4'b0000, 1};
        vecs[8]  = '{20, 4'b1010, 0};
        vecs[9]  = '{31, 4'b1010, 0};
        vecs[10] = '{32, 4'b0000, 1};
        vecs[11] = '{3,  4'b0000, 0};
        vecs[12] = '{4,  4'b0000, 1};

        reset = 1'b1; coin_sense = 1'b0; money_ready = 1'b0;
        repeat (3) cyc();
        chk("reset_valid", s_valid, 0);
        chk("reset_money", s_money, 0);
        chk("reset_reject", s_rej, 0);
        chk("reset_full", s_full, 0);
        chk("reset_busy", s_busy, 0);
        reset = 1'b0;
        repeat (2) cyc();

        // Width table, consumer always ready
        money_ready = 1'b1;
        foreach (vecs[i]) begin
            run_pulse(vecs[i].w, 20, 1000, 0, vc, cd, rc, bc);
            chk($sformatf("tbl_w%0d_vcnt", vecs[i].w), vc, (vecs[i].code != 4'b0000) ? 1 : 0);
            chk($sformatf("tbl_w%0d_code", vecs[i].w), cd, vecs[i].code);
            chk($sformatf("tbl_w%0d_rej", vecs[i].w), rc, vecs[i].rej);
            chk($sformatf("tbl_w%0d_busy", vecs[i].w), bc, (vecs[i].w >= DEB) ? vecs[i].w : 0);
        end

        // Glitched 10-cycle pulse counts as one 5-unit coin
        run_pulse(10, 20, 4, 2, vc, cd, rc, bc);
        chk("glitch_vcnt", vc, 1);
        chk("glitch_code", cd, 4'b0101);
        chk("glitch_rej", rc, 0);
        chk("glitch_busy", bc, 10);

        // Fill the FIFO with the consumer stalled, then drain in order
        money_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run_pulse(10, 10, 1000, 0, vc, cd, rc, bc);
            if (k < 3) chk($sformatf("fill%0d_full", k), s_full, 0);
            else       chk($sformatf("fill%0d_full", k), s_full, 1);
            chk($sformatf("fill%0d_rej", k), rc, (k == 4) ? 1 : 0);
            chk($sformatf("fill%0d_head", k), s_money, 4'b0101);
        end
        money_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("drain%0d_valid", k), s_valid, 1);
            chk($sformatf("drain%0d_money", k), s_money, 4'b0101);
        end
        cyc();
        chk("drain_end_valid", s_valid, 0);
        chk("drain_end_money", s_money, 0);
        chk("drain_end_full", s_full, 0);

        // Jammed coin: busy throughout, single reject, nothing pushed
        run_pulse(70, 20, 1000, 0, vc, cd, rc, bc);
        chk("jam_vcnt", vc, 0);
        chk("jam_rej", rc, 1);
        chk("jam_busy", bc, 70);

        // Reset in the middle of a measurement with a coin already queued
        money_ready = 1'b0;
        run_pulse(10, 15, 1000, 0, vc, cd, rc, bc);
        chk("pre_reset_valid", s_valid, 1);
        coin_sense = 1'b1;
        repeat (10) cyc();
        chk("mid_busy", s_busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("midrst_valid", s_valid, 0);
        chk("midrst_money", s_money, 0);
        chk("midrst_reject", s_rej, 0);
        chk("midrst_full", s_full, 0);
        chk("midrst_busy", s_busy, 0);
        // Sensor still high: re-measured as 12 clocks from the post-reset sample
        money_ready = 1'b1;
        run_pulse(11, 20, 1000, 0, vc, cd, rc, bc);
        chk("remeasure_vcnt", vc, 1);
        chk("remeasure_code", cd, 4'b0101);
        chk("remeasure_rej", rc, 0);

`ifdef COIN_TOTAL_EN
        reset = 1'b1; cyc(); reset = 1'b0; cyc();
        chk("credit_reset", credit_total, 0);
        run_pulse(10, 20, 1000, 0, vc, cd, rc, bc);
        run_pulse(25, 20, 1000, 0, vc, cd, rc, bc);
        run_pulse(17, 20, 1000, 0, vc, cd, rc, bc);
        chk("credit_15", credit_total, 15);
        for (int k = 0; k < 26; k++) run_pulse(25, 10, 1000, 0, vc, cd, rc, bc);
        chk("credit_sat", credit_total, 255);
`endif

        // Randomized traffic against the behavioural model
        reset = 1'b1; cyc(); reset = 1'b0;
        rem_hi = 0; rem_lo = 8; ready_pct = 5; rej_pend = 0; mcredit = 0;
        for (int k = 0; k < 4000; k++) begin
            if (rem_hi > 0) begin
                coin_sense = 1'b1;
                rem_hi--;
            end else if (rem_lo > 0 || k >= 3800) begin
                coin_sense = 1'b0;
                if (rem_lo > 0) rem_lo--;
            end else begin
                case ($urandom_range(0, 9))
                    0:       w = $urandom_range(2, 7);
                    1:       w = $urandom_range(60, 70);
                    default: w = $urandom_range(8, 35);
                endcase
                coin_sense = 1'b1;
                rem_hi = w - 1;
                rem_lo = $urandom_range(5, 12);
                if (w >= DEB) evq.push_back('{k + LAT + w, ref_code(w)});
                ready_pct = $urandom_range(0, 10);
            end
            money_ready = ($urandom_range(1, 10) <= ready_pct);
            cyc();
            chk("rnd_valid", s_valid, (mq.size() != 0));
            chk("rnd_money", s_money, (mq.size() != 0) ? mq[0] : 4'b0000);
            chk("rnd_reject", s_rej, rej_pend);
            chk("rnd_full", s_full, (mq.size() == 4));
            rej_pend    = 0;
            full_before = (mq.size() == 4);
            if (mq.size() != 0 && money_ready) void'(mq.pop_front());
            if (evq.size() != 0 && evq[0].t == k) begin
                ev = evq.pop_front();
                if (ev.code == 4'b0000 || full_before) begin
                    rej_pend = 1;
                end else begin
                    mq.push_back(ev.code);
                    mcredit = (mcredit + int'(ev.code) > 255) ? 255 : mcredit + int'(ev.code);
                end
            end
        end
        chk("rnd_events_done", evq.size(), 0);
`ifdef COIN_TOTAL_EN
        chk("rnd_credit", credit_total, mcredit);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
